// File: rtl/dpa_pkg.sv
// Shared constants and FSM state type for the dot-product accumulator.
package dpa_pkg;

  localparam int OP_W         = 4;
  localparam int PROD_W       = 8;
  localparam int CNT_W        = 8;
  localparam int MULT_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/tag_delay.sv
// Valid/last tag delay line. Stage 0 lines up with the mul_a/mul_b registers,
// stage MULT_LAT lines up with the product arriving on mul_p.
module tag_delay #(
  parameter int MULT_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [MULT_LAT:0] valid_q;
  logic [MULT_LAT:0] last_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the value its predecessor held before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= {valid_q[MULT_LAT-1:0], in_valid};
      last_q  <= {last_q[MULT_LAT-1:0], in_valid & in_last};
    end
  end

  assign out_valid = valid_q[MULT_LAT];
  assign out_last  = last_q[MULT_LAT];

endmodule

// File: rtl/dot_product_accum.sv
// Streams 4-bit operand pairs through an external multiplier and accumulates a
// dot product. Define DPA_SATURATE_EN to clamp instead of wrap on overflow.
module dot_product_accum
  import dpa_pkg::*;
#(
  parameter int ACC_W    = 12,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_p,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t state_q, state_d;

  logic             accept;
  logic             tag_valid;
  logic             tag_last;
  logic             release_result;
  logic [ACC_W:0]   add_full;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  assign accept         = in_valid & in_ready;
  assign release_result = (state_q == ST_HOLD) & out_ready;

  tag_delay #(
    .MULT_LAT (MULT_LAT)
  ) u_tag_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_last   (in_last),
    .out_valid (tag_valid),
    .out_last  (tag_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_last ? ST_DRAIN : ST_ACCUM;
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (tag_valid && tag_last) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (accept) begin
      mul_a <= in_a;
      mul_b <= in_b;
    end
  end

  // One extra bit captures the carry out of the accumulator.
  assign add_full = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, mul_p};
  assign carry    = add_full[ACC_W];

`ifdef DPA_SATURATE_EN
  assign acc_next = carry ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
  assign acc_next = add_full[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (release_result) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (tag_valid) begin
      acc_q <= acc_next;
      ovf_q <= ovf_q | carry;
      if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule
